mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single RAM port between two cores; each core has one icache fetch port and one dcache read/write port.
- Dcache transactions are bursts of BURST_LEN words. Icache transactions are single words.
- Arbitration is round-robin between cores. Within a core, dcache has priority over icache.
- Sits between the per-core caches and the RAM model, and handles the ramstate_t handshake (FREE/BUSY/ACCESS/ERROR).

Parameters:
- NCORE, 2, number of cores; fixed at 2, and the round-robin pointer is 1 bit.
- BURST_LEN, 2, words per dcache transaction; equals 2^DBLK_W.
- CNT_W, 1, width of the burst word counter; equals $clog2(BURST_LEN).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- iREN  in  [NCORE]  icache fetch request, per core.
- iaddr  in  [NCORE] x 32  icache word address.
- iwait  out  [NCORE]  low for one cycle when the fetch word is on iload.
- iload  out  32  shared return data; equals ramload.
- dREN  in  [NCORE]  dcache read request.
- dWEN  in  [NCORE]  dcache write request; wins over dREN when both are high.
- daddr  in  [NCORE] x 32  dcache word address; the requester advances it per word.
- dstore  in  [NCORE] x 32  dcache write data.
- dwait  out  [NCORE]  low for one cycle per completed dcache word.
- dload  out  32  shared return data; equals ramload.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t.
- bus_err  out  1  one-cycle pulse when RAM returns ERROR.

Behaviour:
- FSM states: ARB, SERVE_I, SERVE_D.
- Registered state:
  - gnt_core: 1 bit.
  - rr_ptr: 1 bit, the core with priority.
  - wcnt: CNT_W bits.
  - gnt_wr: 1 bit.
- Reset (synchronous RST=1) values, taking effect on the next edge whatever the state (a mid-burst reset aborts with no further acks):
  - state=ARB, rr_ptr=0, wcnt=0, gnt_core=0.
  - All iwait/dwait=1; ramREN=ramWEN=0; ramaddr=0; ramstore=0; bus_err=0.
- ARB:
  - Priority order is d[p], i[p], d[~p], i[~p], where p=rr_ptr.
  - On selection: register gnt_core, set wcnt=0, latch gnt_wr=dWEN, and go to SERVE_D or SERVE_I.
  - No request: stay in ARB.
  - RAM outputs are idle in ARB (REN/WEN 0, addr/store 0).
  - Minimum latency: request seen in cycle N, RAM driven in cycle N+1.
- SERVE_I:
  - Drive ramREN=1 and ramaddr=iaddr[gnt_core].
  - ramstate==ACCESS: iwait[gnt_core]=0 combinationally that cycle; set rr_ptr=~gnt_core; go to ARB.
  - FREE/BUSY: hold.
- SERVE_D:
  - Drive ramWEN=gnt_wr, ramREN=~gnt_wr, ramaddr=daddr[gnt_core], ramstore=dstore[gnt_core].
  - ramstate==ACCESS: dwait[gnt_core]=0 that cycle.
    - If wcnt==BURST_LEN-1: set rr_ptr=~gnt_core and go to ARB.
    - Otherwise wcnt+1 and stay.
  - The grant is locked for the full burst; the other core waits even if it is requesting.
- Withdrawal: if the granted request drops (iREN, or dREN|dWEN, goes low) before completion, go to ARB next cycle. No ack is given and rr_ptr is unchanged.
- ERROR:
  - ramstate==ERROR in either SERVE state: no ack, bus_err=1 for one cycle, rr_ptr=~gnt_core, go to ARB.
  - The requester re-requests.
- Exclusivity:
  - ramREN and ramWEN are never both 1.
  - At most one of the four wait signals is low in any cycle.
  - Non-granted waits stay 1.
- Data returns: iload and dload are always ramload. They are valid only in the cycle the corresponding wait is low.

Test Plan:
- Single fetch: core0 iREN=1, iaddr=0x40, RAM gives ACCESS on the first serve cycle with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x40 at cycle 1; iwait[0]=0 with iload=0xDEADBEEF at cycle 1; ARB at cycle 2; rr_ptr=1.
- Write burst: core1 dWEN=1, daddr 0x100 then 0x104, dstore 0xA then 0xB, RAM BUSY 2 cycles per word → two dwait[1] low pulses; ramWEN=1 throughout; ramstore matches each word; core0 iREN held high all along gets no grant until after the second pulse.
- Contention: both cores assert dREN and iREN continuously with instant ACCESS, starting after reset (rr_ptr=0) → grant order core0 D burst, core1 D burst, core0 D, core1 D; no core waits more than one burst.
- Intra-core priority: core0 iREN and dREN together → D burst served first; I served after core1's turn, or immediately if core1 is idle.
- ERROR mid-burst: RAM returns ERROR on word 1 of a core0 read → one dwait pulse only, bus_err pulses once, ARB next cycle, rr_ptr=1.
- Reset mid-burst: RST=1 during SERVE_D with wcnt=1 → next cycle state=ARB, all waits=1, ramREN=ramWEN=0, rr_ptr=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-core RAM port arbiter: round-robin between cores, dcache over icache
// within a core, BURST_LEN-word dcache bursts and single-word icache fetches.
package mem_bus_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NCORE     = 2,
  parameter int BURST_LEN = 2,
  parameter int CNT_W     = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCORE-1:0]       iREN,
  input  logic [NCORE-1:0][31:0] iaddr,
  output logic [NCORE-1:0]       iwait,
  output logic [31:0]            iload,
  input  logic [NCORE-1:0]       dREN,
  input  logic [NCORE-1:0]       dWEN,
  input  logic [NCORE-1:0][31:0] daddr,
  input  logic [NCORE-1:0][31:0] dstore,
  output logic [NCORE-1:0]       dwait,
  output logic [31:0]            dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate,
  output logic                   bus_err
);

  typedef enum logic [1:0] {ARB, SERVE_I, SERVE_D} state_t;

  state_t           state;
  logic             gnt_core;
  logic             rr_ptr;
  logic [CNT_W-1:0] wcnt;
  logic             gnt_wr;

  ramstate_t        rs;
  logic [NCORE-1:0] d_req;
  logic             gnt_req;
  logic             ack;
  logic             err;
  logic             sel_valid;
  logic             sel_core;
  logic             sel_d;

  assign rs    = ramstate_t'(ramstate);
  assign d_req = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  // A dropped request overrides whatever the RAM reports that cycle.
  always_comb begin
    gnt_req = 1'b0;
    case (state)
      SERVE_I: gnt_req = iREN[gnt_core];
      SERVE_D: gnt_req = d_req[gnt_core];
      default: gnt_req = 1'b0;
    endcase
  end

  assign ack = gnt_req && (rs == ACCESS);
  assign err = gnt_req && (rs == ERROR);

  // Fixed priority walk: d[p], i[p], d[~p], i[~p].
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    sel_valid = 1'b1;
    sel_core  = rr_ptr;
    sel_d     = 1'b1;
    if (d_req[rr_ptr]) begin
      sel_core = rr_ptr;
      sel_d    = 1'b1;
    end else if (iREN[rr_ptr]) begin
      sel_core = rr_ptr;
      sel_d    = 1'b0;
    end else if (d_req[~rr_ptr]) begin
      sel_core = ~rr_ptr;
      sel_d    = 1'b1;
    end else if (iREN[~rr_ptr]) begin
      sel_core = ~rr_ptr;
      sel_d    = 1'b0;
    end else begin
      sel_valid = 1'b0;
    end
  end

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    bus_err  = 1'b0;
    case (state)
      SERVE_I: begin
        ramREN          = 1'b1;
        ramaddr         = iaddr[gnt_core];
        iwait[gnt_core] = ~ack;
        bus_err         = err;
      end
      SERVE_D: begin
        ramREN          = ~gnt_wr;
        ramWEN          = gnt_wr;
        ramaddr         = daddr[gnt_core];
        ramstore        = dstore[gnt_core];
        dwait[gnt_core] = ~ack;
        bus_err         = err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state    <= ARB;
      rr_ptr   <= 1'b0;
      wcnt     <= '0;
      gnt_core <= 1'b0;
      gnt_wr   <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (sel_valid) begin
            gnt_core <= sel_core;
            wcnt     <= '0;
            gnt_wr   <= sel_d & dWEN[sel_core];
            state    <= sel_d ? SERVE_D : SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (!gnt_req) begin
            state <= ARB;
          end else if (err) begin
            rr_ptr <= ~gnt_core;
            state  <= ARB;
          end else if (ack) begin
            if (state == SERVE_I || wcnt == CNT_W'(BURST_LEN - 1)) begin
              rr_ptr <= ~gnt_core;
              state  <= ARB;
            end else begin
              wcnt <= wcnt + CNT_W'(1);
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int BURST_LEN = 2;

  logic            CLK;
  logic            RST;
  logic [1:0]      iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]      iwait;
  logic [31:0]     iload;
  logic [1:0]      dREN;
  logic [1:0]      dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]      dwait;
  logic [31:0]     dload;
  logic            ramREN;
  logic            ramWEN;
  logic [31:0]     ramaddr;
  logic [31:0]     ramstore;
  logic [31:0]     ramload;
  logic [1:0]      ramstate;
  logic            bus_err;

  mem_bus_arbiter #(.NCORE(2), .BURST_LEN(BURST_LEN), .CNT_W(1)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Reference model: the transaction in flight (none / fetch / burst),
  // its owner, words already completed, and the core currently favoured.
  int   m_mode = 0;  // 0 none, 1 fetch, 2 burst
  logic m_core = 1'b0;
  logic m_wr   = 1'b0;
  int   m_word = 0;
  logic m_ptr  = 1'b0;

  // Observed acks, coded as 2*core + (1 for dcache, 0 for icache).
  int ack_log[$];

  task automatic step();
    logic [1:0]  e_iw, e_dw;
    logic        e_ren, e_wen, req, hit_acc, hit_err, found, c;
    logic [31:0] e_addr, e_store;
    int          n_mode, n_word, lows;
    logic        n_core, n_wr, n_ptr;
    #1;
    e_iw = 2'b11; e_dw = 2'b11; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = '0; e_store = '0; req = 1'b0;
    if (m_mode == 1) begin
      req = iREN[m_core]; e_ren = 1'b1; e_addr = iaddr[m_core];
    end else if (m_mode == 2) begin
      req = dREN[m_core] | dWEN[m_core];
      e_ren = ~m_wr; e_wen = m_wr;
      e_addr = daddr[m_core]; e_store = dstore[m_core];
    end
    hit_acc = req && (ramstate == ACCESS);
    hit_err = req && (ramstate == ERROR);
    if (hit_acc) begin
      if (m_mode == 1) e_iw[m_core] = 1'b0;
      else             e_dw[m_core] = 1'b0;
    end

    n_mode = m_mode; n_core = m_core; n_wr = m_wr; n_word = m_word; n_ptr = m_ptr;
    if (RST) begin
      n_mode = 0; n_ptr = 1'b0; n_word = 0; n_core = 1'b0;
    end else if (m_mode == 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = (k < 2) ? m_ptr : ~m_ptr;
        if (!found && ((k % 2 == 0) ? (dREN[c] | dWEN[c]) : iREN[c])) begin
          found  = 1'b1;
          n_core = c;
          n_mode = (k % 2 == 0) ? 2 : 1;
          n_wr   = (k % 2 == 0) && dWEN[c];
          n_word = 0;
        end
      end
    end else if (!req) begin
      n_mode = 0;
    end else if (hit_err) begin
      n_mode = 0; n_ptr = ~m_core;
    end else if (hit_acc) begin
      if (m_mode == 1 || m_word == BURST_LEN - 1) begin
        n_mode = 0; n_ptr = ~m_core;
      end else begin
        n_word = m_word + 1;
      end
    end

    check("iwait", 32'(iwait), 32'(e_iw));
    check("dwait", 32'(dwait), 32'(e_dw));
    check("ramREN", 32'(ramREN), 32'(e_ren));
    check("ramWEN", 32'(ramWEN), 32'(e_wen));
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("bus_err", 32'(bus_err), 32'(hit_err));
    check("iload", iload, ramload);
    check("dload", dload, ramload);
    check("excl_rw", 32'(ramREN & ramWEN), 32'd0);
    lows = 0;
    for (int k = 0; k < 2; k++) begin
      if (!iwait[k]) begin lows++; ack_log.push_back(2 * k); end
      if (!dwait[k]) begin lows++; ack_log.push_back(2 * k + 1); end
    end
    check("one_ack", 32'(lows > 1), 32'd0);

    @(posedge CLK);
    m_mode = n_mode; m_core = n_core; m_wr = n_wr; m_word = n_word; m_ptr = n_ptr;
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic reset_step();
    idle_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  int pulses;

  initial begin
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_ram", {ramREN, ramWEN, 30'd0}, 32'd0);
    check("rst_addr", ramaddr, 32'd0);
    RST = 1'b0;

    // Single fetch, then a write burst from core1 while core0 fetches.
    iREN = 2'b01; iaddr[0] = 32'h40;
    step();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    check("fetch_ren", 32'(ramREN), 32'd1);
    check("fetch_addr", ramaddr, 32'h40);
    check("fetch_iwait", 32'(iwait), 32'h2);
    check("fetch_iload", iload, 32'hDEADBEEF);
    step();
    idle_inputs();
    iREN = 2'b01; iaddr[0] = 32'h44;
    dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'hA;
    step();
    ack_log.delete();
    for (int w = 0; w < 2; w++) begin
      daddr[1]  = (w == 0) ? 32'h100 : 32'h104;
      dstore[1] = (w == 0) ? 32'hA : 32'hB;
      for (int k = 0; k < 3; k++) begin
        ramstate = (k < 2) ? BUSY : ACCESS;
        #1;
        check("wr_wen", 32'(ramWEN), 32'd1);
        check("wr_store", ramstore, dstore[1]);
        step();
      end
    end
    check("wr_pulses", 32'(ack_log.size()), 32'd2);
    dWEN = 2'b00; ramstate = FREE;
    step();
    ramstate = ACCESS;
    #1;
    check("wr_then_fetch", ramaddr, 32'h44);
    check("wr_then_iwait", 32'(iwait), 32'h2);
    step();

    // Contention: both cores hammer D and I with instant ACCESS.
    reset_step();
    dREN = 2'b11; iREN = 2'b11; ramstate = ACCESS;
    daddr[0] = 32'h1000; daddr[1] = 32'h2000;
    ack_log.delete();
    repeat (12) step();
    check("cont_count", 32'(ack_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < ack_log.size(); k++)
      check("cont_order", 32'(ack_log[k]), ((k / 2) % 2 == 0) ? 32'd1 : 32'd3);

    // Intra-core priority: core0 D before core0 I.
    reset_step();
    iREN = 2'b01; dREN = 2'b01; ramstate = ACCESS;
    ack_log.delete();
    repeat (3) step();
    dREN = 2'b00;
    repeat (2) step();
    check("prio_count", 32'(ack_log.size()), 32'd3);
    if (ack_log.size() == 3) begin
      check("prio_first", 32'(ack_log[0]), 32'd1);
      check("prio_last", 32'(ack_log[2]), 32'd0);
    end

    // ERROR on the second word of a core0 read burst.
    reset_step();
    dREN = 2'b01; daddr[0] = 32'h200; ramstate = ACCESS;
    step();
    step();
    ramstate = ERROR;
    #1;
    check("err_pulse", 32'(bus_err), 32'd1);
    check("err_noack", 32'(dwait), 32'h3);
    step();
    dREN = 2'b11; daddr[1] = 32'h300; ramstate = FREE;
    #1;
    check("err_arb", 32'(ramREN), 32'd0);
    step();
    #1;
    check("err_rr", ramaddr, 32'h300);
    step();

    // Reset in the middle of a burst.
    reset_step();
    dREN = 2'b01; daddr[0] = 32'h500; ramstate = ACCESS;
    step();
    step();
    RST = 1'b1; ramstate = BUSY;
    step();
    RST = 1'b0; dREN = 2'b00; ramstate = ACCESS;
    #1;
    check("mrst_waits", 32'({iwait, dwait}), 32'hF);
    check("mrst_ram", 32'({ramREN, ramWEN}), 32'd0);
    step();
    dREN = 2'b11; daddr[1] = 32'h600; ramstate = FREE;
    step();
    #1;
    check("mrst_rr", ramaddr, 32'h500);
    step();

    // Random traffic against the model.
    reset_step();
    pulses = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(99) < 15) iREN[c] = ~iREN[c];
        if ($urandom_range(99) < 10) dREN[c] = ~dREN[c];
        if ($urandom_range(99) < 10) dWEN[c] = ~dWEN[c];
        iaddr[c]  = $urandom;
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
      end
      ramload = $urandom;
      case ($urandom_range(9))
        0, 1:    ramstate = FREE;
        2, 3, 4: ramstate = BUSY;
        9:       ramstate = ERROR;
        default: ramstate = ACCESS;
      endcase
      RST = ($urandom_range(99) == 0);
      if (RST) ramstate = BUSY;
      step();
    end
    RST = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
